instr_fetch_unit: RTL and testbench

//  Instruction supply side of the Processor's 32-bit instruction input (Read_Addr).

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/prog_mem.sv | 24 ++
 rtl/instr_fetch_unit.sv | 137 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared processor definitions: opcode constants and the fetch-unit state encoding.
package cpu_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_AND   = 8'h02;
  localparam logic [7:0] OP_OR    = 8'h03;
  localparam logic [7:0] OP_MOV   = 8'h08;
  localparam logic [7:0] OP_SUB   = 8'h09;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } fetch_state_e;

  // Byte address of a program word.
  function automatic logic [31:0] word_to_pc(input logic [31:0] word_idx);
    return {word_idx[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/prog_mem.sv
// Program store: DEPTH x 32 register array, one synchronous write port, one combinational read.
module prog_mem #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction supply for the processor: loads a program over valid/ready, then issues each word
// for ISSUE_CYCLES clocks with its byte PC, pulsing done after the last word.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned ISSUE_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_valid_i,
  output logic              load_ready_o,
  input  logic [31:0]       load_data_i,
  input  logic              start_i,
  input  logic              clear_i,
  output logic [31:0]       instruction_o,
  output logic              instr_valid_o,
  output logic [31:0]       pc_o,
  output logic [ADDR_W:0]   count_o,
  output logic              done_o
);

  localparam int unsigned HoldW = (ISSUE_CYCLES > 1) ? $clog2(ISSUE_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldReload = HoldW'(ISSUE_CYCLES - 1);
  localparam logic [ADDR_W:0]  CountFull  = (ADDR_W + 1)'(DEPTH);

  fetch_state_e      state_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W-1:0] idx_q;
  logic [HoldW-1:0]  hold_q;
  logic [31:0]       instr_q;
  logic [31:0]       pc_q;
  logic              valid_q;
  logic              done_q;

  logic              load_ready;
  logic              load_accept;
  logic              has_prog;
  logic              last_word;
  logic [ADDR_W-1:0] next_idx;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;

  assign load_ready  = (state_q == StIdle) && (count_q < CountFull);
  // Clear takes priority, so a load in the same cycle is discarded rather than stored.
  assign load_accept = load_valid_i && load_ready && !clear_i;
  assign has_prog    = (count_q != '0);
  assign last_word   = ({1'b0, idx_q} >= (count_q - 1'b1));
  assign next_idx    = idx_q + 1'b1;
  // Outside RUN the only word ever fetched is word 0 (start/rerun).
  assign rd_addr     = (state_q == StRun) ? next_idx : '0;

  prog_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_prog_mem (
    .clk_i   (clk_i),
    .we_i    (load_accept),
    .waddr_i (count_q[ADDR_W-1:0]),
    .wdata_i (load_data_i),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      count_q <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (clear_i) begin
            count_q <= '0;
          end else if (load_accept) begin
            count_q <= count_q + 1'b1;
          end else if (start_i && has_prog) begin
            state_q <= StRun;
            idx_q   <= '0;
            instr_q <= rd_data;
            pc_q    <= '0;
            valid_q <= 1'b1;
            hold_q  <= HoldReload;
          end
        end
        StRun: begin
          if (hold_q != '0) begin
            hold_q <= hold_q - 1'b1;
          end else if (!last_word) begin
            idx_q   <= next_idx;
            instr_q <= rd_data;
            pc_q    <= word_to_pc(32'(next_idx));
            hold_q  <= HoldReload;
          end else begin
            state_q <= StHalt;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StHalt: begin
          if (clear_i) begin
            state_q <= StIdle;
            count_q <= '0;
            instr_q <= '0;
            pc_q    <= '0;
          end else if (start_i && has_prog) begin
            state_q <= StRun;
            idx_q   <= '0;
            instr_q <= rd_data;
            pc_q    <= '0;
            valid_q <= 1'b1;
            hold_q  <= HoldReload;
          end
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready_o  = load_ready;
  assign instruction_o = instr_q;
  assign instr_valid_o = valid_q;
  assign pc_o          = pc_q;
  assign count_o       = count_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (DEPTH=16, ISSUE_CYCLES=2).
module tb_instr_fetch_unit;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        load_valid_i;
  logic        load_ready_o;
  logic [31:0] load_data_i;
  logic        start_i;
  logic        clear_i;
  logic [31:0] instruction_o;
  logic        instr_valid_o;
  logic [31:0] pc_o;
  logic [4:0]  count_o;
  logic        done_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] prog3 [3] = '{32'h000400FF, 32'h000600AA, 32'h01050603};

  instr_fetch_unit #(
    .DEPTH        (16),
    .ADDR_W       (4),
    .ISSUE_CYCLES (2)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .load_valid_i  (load_valid_i),
    .load_ready_o  (load_ready_o),
    .load_data_i   (load_data_i),
    .start_i       (start_i),
    .clear_i       (clear_i),
    .instruction_o (instruction_o),
    .instr_valid_o (instr_valid_o),
    .pc_o          (pc_o),
    .count_o       (count_o),
    .done_o        (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic load_prog3();
    for (int i = 0; i < 3; i++) begin
      load_valid_i = 1'b1;
      load_data_i  = prog3[i];
      tick();
    end
    load_valid_i = 1'b0;
  endtask

  // Called right after the start edge: checks every held cycle of the 3-word program and done.
  task automatic run_prog3(input string tag);
    for (int k = 0; k < 6; k++) begin
      check({tag, "_instr"}, instruction_o, prog3[k/2]);
      check({tag, "_pc"}, pc_o, 32'(k / 2) * 32'd4);
      check({tag, "_valid"}, {31'b0, instr_valid_o}, 32'd1);
      check({tag, "_nodone"}, {31'b0, done_o}, 32'd0);
      tick();
    end
    check({tag, "_done"}, {31'b0, done_o}, 32'd1);
    check({tag, "_valid_off"}, {31'b0, instr_valid_o}, 32'd0);
    check({tag, "_instr_kept"}, instruction_o, prog3[2]);
    check({tag, "_halt_noready"}, {31'b0, load_ready_o}, 32'd0);
    tick();
    check({tag, "_done_once"}, {31'b0, done_o}, 32'd0);
  endtask

  initial begin
    reset_i      = 1'b1;
    load_valid_i = 1'b0;
    load_data_i  = '0;
    start_i      = 1'b0;
    clear_i      = 1'b0;
    #12;
    check("rst_instr", instruction_o, 32'h0);
    check("rst_valid", {31'b0, instr_valid_o}, 32'd0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_count", {27'b0, count_o}, 32'd0);
    check("rst_done", {31'b0, done_o}, 32'd0);
    reset_i = 1'b0;
    @(negedge clk_i);
    check("rst_ready", {31'b0, load_ready_o}, 32'd1);

    // 1. Three-word program.
    tick();
    load_prog3();
    check("t1_count", {27'b0, count_o}, 32'd3);
    check("t1_ready", {31'b0, load_ready_o}, 32'd1);
    pulse_start();
    run_prog3("t1");

    // 6. Rerun from HALT, then clear back to IDLE.
    pulse_start();
    run_prog3("t6");
    pulse_clear();
    check("t6_clr_count", {27'b0, count_o}, 32'd0);
    check("t6_clr_ready", {31'b0, load_ready_o}, 32'd1);
    check("t6_clr_instr", instruction_o, 32'h0);
    check("t6_clr_pc", pc_o, 32'h0);

    // 3. start with an empty program is ignored.
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      check("t3_valid", {31'b0, instr_valid_o}, 32'd0);
      check("t3_done", {31'b0, done_o}, 32'd0);
      check("t3_ready", {31'b0, load_ready_o}, 32'd1);
      tick();
    end

    // 4. Load and start together: load wins, start must be reasserted.
    load_valid_i = 1'b1;
    load_data_i  = 32'h09030201;
    start_i      = 1'b1;
    tick();
    load_valid_i = 1'b0;
    start_i      = 1'b0;
    check("t4_count", {27'b0, count_o}, 32'd1);
    check("t4_idle_valid", {31'b0, instr_valid_o}, 32'd0);
    check("t4_idle_ready", {31'b0, load_ready_o}, 32'd1);
    tick();
    check("t4_still_idle", {31'b0, instr_valid_o}, 32'd0);
    pulse_start();
    check("t4_instr", instruction_o, 32'h09030201);
    check("t4_pc", pc_o, 32'h0);
    check("t4_valid", {31'b0, instr_valid_o}, 32'd1);
    tick();
    check("t4_hold", instruction_o, 32'h09030201);
    tick();
    check("t4_done", {31'b0, done_o}, 32'd1);
    pulse_clear();

    // 5. Reset during RUN on the second word aborts at once.
    load_prog3();
    pulse_start();
    tick();
    tick();
    check("t5_second", instruction_o, prog3[1]);
    check("t5_second_pc", pc_o, 32'd4);
    #2 reset_i = 1'b1;
    #1;
    check("t5_instr", instruction_o, 32'h0);
    check("t5_valid", {31'b0, instr_valid_o}, 32'd0);
    check("t5_pc", pc_o, 32'h0);
    check("t5_count", {27'b0, count_o}, 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    tick();
    check("t5_ready", {31'b0, load_ready_o}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      check("t5_nodone", {31'b0, done_o}, 32'd0);
      tick();
    end

    // 2. Fill all 16 words; a held 17th load is not taken.
    for (int i = 0; i < 16; i++) begin
      load_valid_i = 1'b1;
      load_data_i  = 32'h0A000000 + 32'(i);
      tick();
    end
    check("t2_count16", {27'b0, count_o}, 32'd16);
    check("t2_ready_low", {31'b0, load_ready_o}, 32'd0);
    load_data_i = 32'hDEADBEEF;
    tick();
    tick();
    tick();
    load_valid_i = 1'b0;
    check("t2_count_held", {27'b0, count_o}, 32'd16);
    pulse_start();
    for (int w = 0; w < 16; w++) begin
      check("t2_instr", instruction_o, 32'h0A000000 + 32'(w));
      check("t2_pc", pc_o, 32'(w) * 32'd4);
      tick();
      tick();
    end
    check("t2_done", {31'b0, done_o}, 32'd1);
    check("t2_last_kept", instruction_o, 32'h0A00000F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
